// File: rtl/arith_unit.sv
// Registered signed ALU: ADD, SUB, MUL and NEG on WIDTH-bit two's-complement
// operands, with an overflow flag and optional saturation of the result.
module arith_unit #(
   parameter int WIDTH    = 4,
   parameter bit SATURATE = 1'b0
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   input  logic [1:0]       sel,
   output logic [WIDTH-1:0] Q,
   output logic             overflow
);

   localparam int PW = 2 * WIDTH;
   localparam logic [WIDTH-1:0] MaxVal = {1'b0, {(WIDTH-1){1'b1}}};
   localparam logic [WIDTH-1:0] MinVal = {1'b1, {(WIDTH-1){1'b0}}};

   logic [PW-1:0]    aExt;
   logic [PW-1:0]    bExt;
   logic [PW-1:0]    trueRes;
   logic [WIDTH-1:0] result_d;
   logic [WIDTH-1:0] result_q;
   logic             overflow_d;
   logic             overflow_q;

   assign aExt = {{WIDTH{A[WIDTH-1]}}, A};
   assign bExt = {{WIDTH{B[WIDTH-1]}}, B};

   // trueRes is wide enough to hold every exact result, including the full product
   always_comb begin
      trueRes    = '0;
      overflow_d = 1'b0;
      case (sel)
         2'b00: begin
            trueRes    = aExt + bExt;
            overflow_d = (A[WIDTH-1] == B[WIDTH-1]) && (trueRes[WIDTH-1] != A[WIDTH-1]);
         end
         2'b01: begin
            trueRes    = aExt - bExt;
            overflow_d = (A[WIDTH-1] != B[WIDTH-1]) && (trueRes[WIDTH-1] != A[WIDTH-1]);
         end
         2'b10: begin
            trueRes    = aExt * bExt;
            overflow_d = (trueRes[PW-1:WIDTH-1] != {(WIDTH+1){trueRes[WIDTH-1]}});
         end
         default: begin
            trueRes    = '0 - aExt;
            overflow_d = (A == MinVal);
         end
      endcase

      result_d = trueRes[WIDTH-1:0];
      if (SATURATE && overflow_d) begin
         result_d = trueRes[PW-1] ? MinVal : MaxVal;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         result_q   <= '0;
         overflow_q <= 1'b0;
      end else begin
         result_q   <= result_d;
         overflow_q <= overflow_d;
      end
   end

   assign Q        = result_q;
   assign overflow = overflow_q;

endmodule

// File: tb/tb_arith_unit.sv
// Self-checking bench for arith_unit: a wrapping and a saturating instance
// share stimulus; directed vectors first, then an exhaustive back-to-back sweep.
module tb_arith_unit;

   logic              clk = 1'b0;
   logic              rst = 1'b1;
   logic signed [3:0] a   = '0;
   logic signed [3:0] b   = '0;
   logic [1:0]        sel = '0;
   logic signed [3:0] qWrap;
   logic signed [3:0] qSat;
   logic              ovWrap;
   logic              ovSat;

   int errCount   = 0;
   int checkCount = 0;

   arith_unit #(.WIDTH(4), .SATURATE(1'b0)) dutWrap (
      .clk(clk), .rst(rst), .A(a), .B(b), .sel(sel), .Q(qWrap), .overflow(ovWrap)
   );

   arith_unit #(.WIDTH(4), .SATURATE(1'b1)) dutSat (
      .clk(clk), .rst(rst), .A(a), .B(b), .sel(sel), .Q(qSat), .overflow(ovSat)
   );

   always #5 clk = ~clk;

   task automatic checkOutput(input string tag, input int observed, input int expected);
      checkCount++;
      if (observed != expected) begin
         errCount++;
         $display("[TB] FAIL %s: got %0d, expected %0d", tag, observed, expected);
      end
   endtask

   // Drive one operation and sample outputs shortly after the capturing edge
   task automatic applyStimulus(input int av, input int bv, input int sv);
      a   = 4'(av);
      b   = 4'(bv);
      sel = 2'(sv);
      @(posedge clk);
      #1;
   endtask

   // Integer reference: exact result, then wrap or clamp into -8..7
   task automatic refModel(input int av, input int bv, input int sv,
                           output int qw, output int qs, output int ov);
      int t;
      case (sv)
         0:       t = av + bv;
         1:       t = av - bv;
         2:       t = av * bv;
         default: t = -av;
      endcase
      ov = (t < -8 || t > 7) ? 1 : 0;
      qw = t & 15;
      if (qw > 7) qw = qw - 16;
      if (t > 7)       qs = 7;
      else if (t < -8) qs = -8;
      else             qs = t;
   endtask

   // Directed vectors: a, b, sel, wrapped Q, overflow, saturated Q
   int va[12]  = '{ 3,  7, -8, -8,  2, -2,  3, -8,  4,  5, -8,  0};
   int vb[12]  = '{ 2,  1, -1,  1,  5,  3,  3, -1, -2,  7,  7,  7};
   int vs[12]  = '{ 0,  0,  0,  1,  1,  2,  2,  2,  2,  3,  3,  3};
   int vq[12]  = '{ 5, -8,  7,  7, -3, -6, -7, -8, -8, -5, -8,  0};
   int vov[12] = '{ 0,  1,  1,  1,  0,  0,  1,  1,  0,  0,  1,  0};
   int vqs[12] = '{ 5,  7, -8, -8, -3, -6,  7,  7, -8, -5,  7,  0};

   initial begin
      int qw, qs, ov, idx;

      // Reset captured while 7+1 is on the inputs, then released
      rst = 1'b1;
      applyStimulus(7, 1, 0);
      checkOutput("reset Q wrap", int'(qWrap), 0);
      checkOutput("reset ov wrap", int'(ovWrap), 0);
      checkOutput("reset Q sat", int'(qSat), 0);
      checkOutput("reset ov sat", int'(ovSat), 0);
      rst = 1'b0;
      applyStimulus(7, 1, 0);
      checkOutput("post-reset Q wrap", int'(qWrap), -8);
      checkOutput("post-reset ov wrap", int'(ovWrap), 1);
      checkOutput("post-reset Q sat", int'(qSat), 7);

      for (int i = 0; i < 12; i++) begin
         applyStimulus(va[i], vb[i], vs[i]);
         checkOutput($sformatf("dir%0d Q wrap", i), int'(qWrap), vq[i]);
         checkOutput($sformatf("dir%0d ov wrap", i), int'(ovWrap), vov[i]);
         checkOutput($sformatf("dir%0d Q sat", i), int'(qSat), vqs[i]);
         checkOutput($sformatf("dir%0d ov sat", i), int'(ovSat), vov[i]);
      end

      // Exhaustive sweep with a one-edge reset injected partway through
      idx = 0;
      for (int s = 0; s < 4; s++) begin
         for (int x = -8; x < 8; x++) begin
            for (int y = -8; y < 8; y++) begin
               if (idx == 517) begin
                  rst = 1'b1;
                  applyStimulus(x, y, s);
                  checkOutput("sweep reset Q wrap", int'(qWrap), 0);
                  checkOutput("sweep reset ov wrap", int'(ovWrap), 0);
                  checkOutput("sweep reset Q sat", int'(qSat), 0);
                  checkOutput("sweep reset ov sat", int'(ovSat), 0);
                  rst = 1'b0;
               end
               applyStimulus(x, y, s);
               refModel(x, y, s, qw, qs, ov);
               checkOutput($sformatf("sweep s%0d %0d,%0d Q wrap", s, x, y), int'(qWrap), qw);
               checkOutput($sformatf("sweep s%0d %0d,%0d ov wrap", s, x, y), int'(ovWrap), ov);
               checkOutput($sformatf("sweep s%0d %0d,%0d Q sat", s, x, y), int'(qSat), qs);
               checkOutput($sformatf("sweep s%0d %0d,%0d ov sat", s, x, y), int'(ovSat), ov);
               idx++;
            end
         end
      end

      $display("Result: errors=%0d of %0d checks", errCount, checkCount);
      $finish;
   end

endmodule
